// File: rtl/mfm_pkg.sv
// Shared MFM read-path definitions: FSM encoding, A1 sync mark, cell-pair layout.
package mfm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOCK = 3'd1,
        HUNT = 3'd2,
        SYNC = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } rd_state_t;

    localparam logic [15:0] MFM_SYNC_A1 = 16'h4489;

    // Each cell pair is {clock, data}, so data cells sit on the even positions.
    localparam int MFM_DATA_LSB = 0;

    function automatic logic [7:0] mfm_data_bits(input logic [15:0] cells);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i] = cells[2*i + MFM_DATA_LSB];
        end
        return d;
    endfunction

endpackage

// File: rtl/mfm_sync_shift.sv
// Cell shift register, sync-word comparator, 16-cell framing counter and data-bit extraction.
// Latency: match is combinational on the register; word_rdy is high the cycle after the 16th cell.
// Backpressure: none, every qualified cell is consumed.
module mfm_sync_shift
    import mfm_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = MFM_SYNC_A1
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       clr_all,
    input  logic       clr_cnt,
    input  logic       cell_valid,
    input  logic       cell_bit,
    output logic       match,
    output logic       word_rdy,
    output logic [7:0] data_byte
);

    logic [15:0] sr;
    logic [3:0]  cell_cnt;

    always_ff @(posedge clk_50) begin
        if (reset || clr_all) begin
            sr       <= '0;
            cell_cnt <= '0;
            word_rdy <= 1'b0;
        end else begin
            if (cell_valid) begin
                sr <= {sr[14:0], cell_bit};
            end
            // A cell arriving while the framing restarts is the first cell of the new word.
            if (clr_cnt) begin
                cell_cnt <= cell_valid ? 4'd1 : 4'd0;
            end else if (cell_valid) begin
                cell_cnt <= cell_cnt + 4'd1;
            end
            word_rdy <= cell_valid && !clr_cnt && (cell_cnt == 4'd15);
        end
    end

    assign match     = (sr == SYNC_WORD);
    assign data_byte = mfm_data_bits(sr);

endmodule

// File: rtl/mfm_read_ctrl.sv
// MFM sector read controller: DPLL lock, sync-mark hunt, byte framing, timeout and lock-loss handling.
// Latency: byte_valid two cycles after the 16th cell of a byte; sync_found two cycles after the last sync cell.
// Backpressure: none, the cell stream cannot be stalled; abort is the only way to cut a read short.
module mfm_read_ctrl
    import mfm_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD    = MFM_SYNC_A1,
    parameter int          SYNC_COUNT   = 3,
    parameter int          SECTOR_BYTES = 512,
    parameter logic [31:0] TIMEOUT      = 32'd500000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pll_locked,
    input  logic       cell_valid,
    input  logic       cell_bit,
    output logic       pll_enable,
    output logic       pll_resync,
    output logic       busy,
    output logic       sync_found,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       done,
    output logic       error
);

    localparam int SCW = $clog2(SYNC_COUNT + 1);
    localparam int BCW = $clog2(SECTOR_BYTES + 1);
    localparam logic [SCW-1:0] SYNC_LAST    = SCW'(SYNC_COUNT - 1);
    localparam logic [BCW-1:0] BYTE_LAST    = BCW'(SECTOR_BYTES - 1);
    localparam logic [31:0]    TIMEOUT_LAST = TIMEOUT - 32'd1;

    rd_state_t      state, state_n;
    logic [SCW-1:0] sync_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [31:0]    cyc_cnt;

    logic       clr_all, clr_cnt, sync_hit, byte_take, sync_load, sync_inc;
    logic       match, word_rdy, lock_lost, timed_out;
    logic [7:0] data_byte;

    mfm_sync_shift #(
        .SYNC_WORD (SYNC_WORD)
    ) u_shift (
        .clk_50     (clk_50),
        .reset      (reset),
        .clr_all    (clr_all),
        .clr_cnt    (clr_cnt),
        .cell_valid (cell_valid),
        .cell_bit   (cell_bit),
        .match      (match),
        .word_rdy   (word_rdy),
        .data_byte  (data_byte)
    );

    // cyc_cnt holds cycles elapsed since start, so the ERR edge lands exactly TIMEOUT cycles after it.
    assign lock_lost = !pll_locked && (state == HUNT || state == SYNC || state == DATA);
    assign timed_out = (cyc_cnt == TIMEOUT_LAST) && (state == LOCK || state == HUNT || state == SYNC);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_all   = 1'b0;
        clr_cnt   = 1'b0;
        sync_hit  = 1'b0;
        byte_take = 1'b0;
        sync_load = 1'b0;
        sync_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOCK;
                    clr_all = 1'b1;
                end
            end
            LOCK: begin
                if (timed_out) begin
                    state_n = ERR;
                end else if (pll_locked) begin
                    state_n = HUNT;
                end
            end
            HUNT: begin
                if (lock_lost || timed_out) begin
                    state_n = ERR;
                end else if (match) begin
                    clr_cnt   = 1'b1;
                    sync_load = 1'b1;
                    if (SYNC_COUNT == 1) begin
                        state_n  = DATA;
                        sync_hit = 1'b1;
                    end else begin
                        state_n = SYNC;
                    end
                end
            end
            SYNC: begin
                if (lock_lost || timed_out) begin
                    state_n = ERR;
                end else if (word_rdy) begin
                    if (!match) begin
                        state_n = HUNT;
                    end else if (sync_cnt == SYNC_LAST) begin
                        state_n  = DATA;
                        sync_hit = 1'b1;
                    end else begin
                        sync_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (lock_lost) begin
                    state_n = ERR;
                end else if (word_rdy) begin
                    byte_take = 1'b1;
                    if (byte_cnt == BYTE_LAST) begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n   = IDLE;
            clr_all   = 1'b0;
            clr_cnt   = 1'b0;
            sync_hit  = 1'b0;
            byte_take = 1'b0;
            sync_load = 1'b0;
            sync_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync_cnt   <= '0;
            byte_cnt   <= '0;
            cyc_cnt    <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
        end else begin
            sync_found <= sync_hit;
            byte_valid <= byte_take;
            if (byte_take) begin
                byte_out <= data_byte;
                byte_cnt <= byte_cnt + BCW'(1);
            end else if (clr_all) begin
                byte_cnt <= '0;
            end
            if (clr_all) begin
                cyc_cnt <= 32'd1;
            end else if (state != IDLE) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (sync_load) begin
                sync_cnt <= SCW'(1);
            end else if (sync_inc) begin
                sync_cnt <= sync_cnt + SCW'(1);
            end else if (state_n != SYNC) begin
                sync_cnt <= '0;
            end
        end
    end

    assign pll_resync = (state == IDLE) && start && !abort && !reset;
    assign pll_enable = (state == LOCK) || (state == HUNT) || (state == SYNC) || (state == DATA);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

endmodule

// File: tb/tb_mfm_read_ctrl.sv
// Directed bench for mfm_read_ctrl: nominal read, false sync, timeout, lock loss, abort and mid-read reset.
module tb_mfm_read_ctrl;

    logic       clk_50 = 1'b0;
    logic       reset, start, abort, pll_locked, cell_valid, cell_bit;
    logic       pll_enable, pll_resync, busy, sync_found, byte_valid, done, error;
    logic [7:0] byte_out;
    logic [14:0] outs;

    int errors = 0;
    int checks = 0;
    int n_sync = 0, n_byte = 0, n_done = 0, n_err = 0;
    logic [7:0] got[$];
    logic [7:0] exp_bytes [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    localparam logic [15:0] A1   = 16'h4489;
    localparam logic [15:0] JUNK = 16'h5554;

    mfm_read_ctrl #(
        .SECTOR_BYTES (4),
        .TIMEOUT      (32'd1000)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pll_locked (pll_locked),
        .cell_valid (cell_valid),
        .cell_bit   (cell_bit),
        .pll_enable (pll_enable),
        .pll_resync (pll_resync),
        .busy       (busy),
        .sync_found (sync_found),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .done       (done),
        .error      (error)
    );

    always #5 clk_50 = ~clk_50;

    assign outs = {pll_enable, pll_resync, busy, sync_found, byte_valid, done, error, byte_out};

    always @(negedge clk_50) begin
        if (sync_found) n_sync++;
        if (byte_valid) begin
            n_byte++;
            got.push_back(byte_out);
        end
        if (done)  n_done++;
        if (error) n_err++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    function automatic logic [15:0] mfm_enc(input logic [7:0] d, input logic prev);
        logic [15:0] w;
        logic p;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w[2*i+1] = ~(p | d[i]);
            w[2*i]   = d[i];
            p        = d[i];
        end
        return w;
    endfunction

    // mode 1 drops lock, mode 2 asserts reset, both in the cycle the word completes.
    task automatic send_word(input logic [15:0] w, input int mode);
        for (int i = 15; i >= 0; i--) begin
            cell_valid = 1'b1;
            cell_bit   = w[i];
            cyc();
            cell_valid = 1'b0;
            cell_bit   = 1'b0;
            if (i == 0 && mode == 1) pll_locked = 1'b0;
            if (i == 0 && mode == 2) begin
                reset = 1'b1;
                cyc();
            end else begin
                repeat (3) cyc();
            end
        end
    endtask

    task automatic send_bytes(input int n, input int last_mode);
        logic p;
        p = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_word(mfm_enc(exp_bytes[i], p), (i == n - 1) ? last_mode : 0);
            p = exp_bytes[i][0];
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        pll_locked = 1'b0; cell_valid = 1'b0; cell_bit = 1'b0;
        repeat (3) cyc();
        checks++;
        if (outs !== 15'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0000", outs);
        end
        start = 1'b0; abort = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (outs !== 15'h0) begin
            errors++;
            $display("FAIL idle_outs: got %h want 0000", outs);
        end
    endtask

    task automatic run_nominal(input string tag);
        int bs, bb, bd, be;
        bs = n_sync; bb = n_byte; bd = n_done; be = n_err;
        pll_locked = 1'b0;
        start = 1'b1;
        #1;
        checks++;
        if (pll_resync !== 1'b1) begin
            errors++;
            $display("FAIL %s resync: got %b want 1", tag, pll_resync);
        end
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, pll_enable, pll_resync} !== 3'b110) begin
            errors++;
            $display("FAIL %s lock_state: busy/en/resync got %b want 110", tag, {busy, pll_enable, pll_resync});
        end
        repeat (10) cyc();
        pll_locked = 1'b1;
        repeat (3) send_word(A1, 0);
        send_bytes(4, 0);
        repeat (5) cyc();
        checks++;
        if (n_sync - bs !== 1) begin
            errors++;
            $display("FAIL %s sync_count: got %0d want 1", tag, n_sync - bs);
        end
        checks++;
        if (n_byte - bb !== 4) begin
            errors++;
            $display("FAIL %s byte_count: got %0d want 4", tag, n_byte - bb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (n_byte <= bb + i) begin
                errors++;
                $display("FAIL %s byte%0d: missing want %h", tag, i, exp_bytes[i]);
            end else if (got[bb+i] !== exp_bytes[i]) begin
                errors++;
                $display("FAIL %s byte%0d: got %h want %h", tag, i, got[bb+i], exp_bytes[i]);
            end
        end
        checks++;
        if (n_done - bd !== 1 || n_err - be !== 0) begin
            errors++;
            $display("FAIL %s done_err: done %0d err %0d want 1 0", tag, n_done - bd, n_err - be);
        end
        checks++;
        if ({busy, pll_enable} !== 2'b00) begin
            errors++;
            $display("FAIL %s end_idle: busy/en got %b want 00", tag, {busy, pll_enable});
        end
        checks++;
        if (byte_out !== 8'h3C) begin
            errors++;
            $display("FAIL %s byte_hold: got %h want 3c", tag, byte_out);
        end
    endtask

    task automatic test_false_sync();
        int bs;
        bs = n_sync;
        pll_locked = 1'b1;
        start_pulse();
        send_word(A1, 0); send_word(A1, 0); send_word(JUNK, 0);
        send_word(A1, 0); send_word(A1, 0);
        checks++;
        if (n_sync - bs !== 0) begin
            errors++;
            $display("FAIL false_sync_early: got %0d want 0", n_sync - bs);
        end
        send_word(A1, 0);
        checks++;
        if (n_sync - bs !== 1) begin
            errors++;
            $display("FAIL false_sync_third: got %0d want 1", n_sync - bs);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL false_sync_abort: busy got %b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        int n, be;
        be = n_err;
        pll_locked = 1'b0;
        start_pulse();
        n = 1;
        while (error !== 1'b1 && n < 1100) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 1000) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 1000", n);
        end
        cyc();
        checks++;
        if ({error, pll_enable, busy} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_after: err/en/busy got %b want 000", {error, pll_enable, busy});
        end
        checks++;
        if (n_err - be !== 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d want 1", n_err - be);
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_lock_loss();
        int bb, bd, be;
        bb = n_byte; bd = n_done; be = n_err;
        pll_locked = 1'b1;
        start_pulse();
        repeat (3) send_word(A1, 0);
        send_bytes(3, 1);
        send_word(mfm_enc(8'h3C, 1'b1), 0);
        checks++;
        if (n_byte - bb !== 2) begin
            errors++;
            $display("FAIL lockloss_bytes: got %0d want 2", n_byte - bb);
        end
        checks++;
        if (n_byte >= bb + 2 && got[bb+1] !== 8'h00) begin
            errors++;
            $display("FAIL lockloss_byte1: got %h want 00", got[bb+1]);
        end
        checks++;
        if (n_err - be !== 1 || n_done - bd !== 0) begin
            errors++;
            $display("FAIL lockloss_err_done: err %0d done %0d want 1 0", n_err - be, n_done - bd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL lockloss_idle: busy got %b want 0", busy);
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_abort_start();
        int bb, bd, be;
        bb = n_byte; bd = n_done; be = n_err;
        pll_locked = 1'b1;
        start_pulse();
        repeat (3) send_word(A1, 0);
        send_bytes(1, 0);
        abort = 1'b1; start = 1'b1;
        #1;
        checks++;
        if (pll_resync !== 1'b0) begin
            errors++;
            $display("FAIL abort_resync_in_data: got %b want 0", pll_resync);
        end
        cyc();
        abort = 1'b0;
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            errors++;
            $display("FAIL abort_next: busy/done/err got %b want 000", {busy, done, error});
        end
        #1;
        checks++;
        if (pll_resync !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_resync: got %b want 1", pll_resync);
        end
        cyc();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: busy got %b want 1", busy);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (2) cyc();
        checks++;
        if (n_byte - bb !== 1 || n_done - bd !== 0 || n_err - be !== 0) begin
            errors++;
            $display("FAIL abort_counts: bytes %0d done %0d err %0d want 1 0 0", n_byte - bb, n_done - bd, n_err - be);
        end
    endtask

    task automatic test_reset_mid_data();
        int bb, bd, be;
        bb = n_byte; bd = n_done; be = n_err;
        pll_locked = 1'b1;
        start_pulse();
        repeat (3) send_word(A1, 0);
        send_bytes(2, 2);
        checks++;
        if (outs !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid_outs: got %h want 0000", outs);
        end
        checks++;
        if (n_byte - bb !== 1 || n_done - bd !== 0 || n_err - be !== 0) begin
            errors++;
            $display("FAIL reset_mid_counts: bytes %0d done %0d err %0d want 1 0 0", n_byte - bb, n_done - bd, n_err - be);
        end
        reset = 1'b0;
        cyc();
        run_nominal("after_reset");
    endtask

    initial begin
        test_reset();
        run_nominal("nominal");
        test_false_sync();
        test_timeout();
        test_lock_loss();
        test_abort_start();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
